// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared types and widths for the data-RAM arbiter.
//   DataWidth / INS_ADDR_BUS : default data and address widths of the SOPC.
//   arb_state_e              : arbiter FSM states (S_CPU default, S_DMA burst).
//   arb_owner_e              : per-cycle RAM owner (NONE / CPU / DMA).
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

  localparam int DataWidth    = 32;
  localparam int INS_ADDR_BUS = 32;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } arb_owner_e;

endpackage

// File: rtl/ram_arbiter_sat_cnt.sv
// ---------------------------------------------------------------------------
// arb_sat_cnt
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count this cycle
//   cnt   : current count
// ---------------------------------------------------------------------------
module arb_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != 32'hFFFF_FFFF)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares the single-port data RAM between the CPU data port (master 0,
// default priority) and a DMA/loader port (master 1, req/gnt handshake).
// A wait counter forces a bounded DMA burst after MAX_WAIT contended cycles,
// and a burst counter returns the RAM to the CPU after MAX_BURST beats.
//
// Optional feature macro: ARB_PERF_CNT_EN
//   adds stall_cycles / dma_beats saturating performance counters.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   m0_ram_en .. m0_wdata     : CPU request (enable, write, lanes, addr, data)
//   m0_rdata, cpu_stall       : CPU read data, pipeline hold
//   m1_req .. m1_wdata        : DMA request (req, write, lanes, addr, data)
//   m1_gnt, m1_rdata          : DMA beat accepted, DMA read data
//   ram_en .. data_to_ram     : RAM command
//   data_from_ram             : RAM read data (combinational)
//   stall_cycles, dma_beats   : perf counters (ARB_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DW        = DataWidth,
  parameter int AW        = INS_ADDR_BUS,
  parameter int MAX_WAIT  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_ram_en,
  input  logic          m0_wr_en,
  input  logic [3:0]    m0_bits_sel,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          cpu_stall,
  input  logic          m1_req,
  input  logic          m1_wr_en,
  input  logic [3:0]    m1_bits_sel,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          wr_en,
  output logic [3:0]    Bits_Sel,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] data_to_ram,
  input  logic [DW-1:0] data_from_ram
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   dma_beats
`endif
);

  localparam int WCW = $clog2(MAX_WAIT) + 1;
  localparam int BCW = $clog2(MAX_BURST) + 1;
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MAX_WAIT - 1);
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

  arb_state_e     st, st_nxt;
  arb_owner_e     owner;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic [BCW-1:0] burst_cnt, burst_nxt;

  // Owner is decided in the same cycle as the request. Holding reset forces
  // NONE so every output is zero regardless of what the masters drive.
  always_comb begin
    owner = OWN_NONE;
    if (rst_n) begin
      if (st == S_DMA) begin
        if (m1_req)         owner = OWN_DMA;
        else if (m0_ram_en) owner = OWN_CPU;
      end else begin
        if (m0_ram_en)      owner = OWN_CPU;
        else if (m1_req)    owner = OWN_DMA;
      end
    end
  end

  always_comb begin
    ram_en      = 1'b0;
    wr_en       = 1'b0;
    Bits_Sel    = '0;
    ram_addr_o  = '0;
    data_to_ram = '0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    cpu_stall   = 1'b0;
    m1_gnt      = 1'b0;
    case (owner)
      OWN_CPU: begin
        ram_en      = 1'b1;
        wr_en       = m0_wr_en;
        Bits_Sel    = m0_bits_sel;
        ram_addr_o  = m0_addr;
        data_to_ram = m0_wdata;
        m0_rdata    = data_from_ram;
      end
      OWN_DMA: begin
        ram_en      = 1'b1;
        wr_en       = m1_wr_en;
        Bits_Sel    = m1_bits_sel;
        ram_addr_o  = m1_addr;
        data_to_ram = m1_wdata;
        m1_rdata    = data_from_ram;
        m1_gnt      = 1'b1;
        // The CPU only needs to be held if it actually wanted the RAM.
        cpu_stall   = m0_ram_en;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_nxt    = st;
    wait_nxt  = wait_cnt;
    burst_nxt = burst_cnt;
    case (st)
      S_CPU: begin
        burst_nxt = '0;
        if (m1_req && m0_ram_en) begin
          // Contended cycle: the DMA loses, but only MAX_WAIT times in a row.
          if (wait_cnt == WAIT_LAST) begin
            st_nxt   = S_DMA;
            wait_nxt = '0;
          end else begin
            wait_nxt = wait_cnt + WCW'(1);
          end
        end else begin
          wait_nxt = '0;
        end
      end
      S_DMA: begin
        wait_nxt = '0;
        if (!m1_req || (burst_cnt == BURST_LAST)) begin
          st_nxt    = S_CPU;
          burst_nxt = '0;
        end else begin
          burst_nxt = burst_cnt + BCW'(1);
        end
      end
      default: begin
        st_nxt    = S_CPU;
        wait_nxt  = '0;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_CPU;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      st        <= st_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  end

`ifdef ARB_PERF_CNT_EN
  arb_sat_cnt u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cpu_stall),
    .cnt   (stall_cycles)
  );

  arb_sat_cnt u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (m1_gnt),
    .cnt   (dma_beats)
  );
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter (MAX_WAIT = 8, MAX_BURST = 4) with a small
// behavioural RAM: combinational read, byte-lane write on the clock edge.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_ram_en, m0_wr_en;
  logic [3:0]  m0_bits_sel;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        cpu_stall;
  logic        m1_req, m1_wr_en;
  logic [3:0]  m1_bits_sel;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_gnt;
  logic        ram_en, wr_en;
  logic [3:0]  Bits_Sel;
  logic [31:0] ram_addr_o, data_to_ram, data_from_ram;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] stall_cycles, dma_beats;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  ram_arbiter #(.DW(32), .AW(32), .MAX_WAIT(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_ram_en    (m0_ram_en),
    .m0_wr_en     (m0_wr_en),
    .m0_bits_sel  (m0_bits_sel),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_rdata     (m0_rdata),
    .cpu_stall    (cpu_stall),
    .m1_req       (m1_req),
    .m1_wr_en     (m1_wr_en),
    .m1_bits_sel  (m1_bits_sel),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_gnt       (m1_gnt),
    .m1_rdata     (m1_rdata),
    .ram_en       (ram_en),
    .wr_en        (wr_en),
    .Bits_Sel     (Bits_Sel),
    .ram_addr_o   (ram_addr_o),
    .data_to_ram  (data_to_ram),
    .data_from_ram(data_from_ram)
`ifdef ARB_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .dma_beats    (dma_beats)
`endif
  );

  assign data_from_ram = mem[ram_addr_o[5:2]];

  always @(posedge clk) begin
    if (ram_en && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (Bits_Sel[b]) mem[ram_addr_o[5:2]][8*b +: 8] <= data_to_ram[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // 1. Reset held with both masters requesting.
    rst_n       = 1'b0;
    m0_ram_en   = 1'b1;
    m0_wr_en    = 1'b1;
    m0_bits_sel = 4'hF;
    m0_addr     = 32'h10;
    m0_wdata    = 32'hDEAD_BEEF;
    m1_req      = 1'b1;
    m1_wr_en    = 1'b0;
    m1_bits_sel = 4'hF;
    m1_addr     = 32'h20;
    m1_wdata    = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ram_en", {31'b0, ram_en}, 32'd0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("rst_addr", ram_addr_o, 32'h0);
    chk("rst_st", 32'(dut.st), 32'(S_CPU));

    // Release: CPU write of 0xDEADBEEF to 0x10 wins over the DMA.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ram_en", {31'b0, ram_en}, 32'd1);
    chk("rel_wr_en", {31'b0, wr_en}, 32'd1);
    chk("rel_addr", ram_addr_o, 32'h10);
    chk("rel_wdata", data_to_ram, 32'hDEAD_BEEF);
    chk("rel_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("rel_stall", {31'b0, cpu_stall}, 32'd0);

    // 2. CPU read-back; the contended cycle above bumped wait_cnt to 1.
    @(negedge clk);
    m1_req   = 1'b0;
    m0_wr_en = 1'b0;
    #1;
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_rdata", m1_rdata, 32'h0);
    chk("rd_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rd_wait1", 32'(dut.wait_cnt), 32'd1);

    // 3. DMA only: write 0x12345678 to 0x20, then read it twice.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m0_ram_en = 1'b0;
      m1_req    = 1'b1;
      m1_wr_en  = (k == 0);
      m1_wdata  = 32'h1234_5678;
      #1;
      chk("dma_gnt", {31'b0, m1_gnt}, 32'd1);
      chk("dma_stall", {31'b0, cpu_stall}, 32'd0);
      chk("dma_addr", ram_addr_o, 32'h20);
      chk("dma_st", 32'(dut.st), 32'(S_CPU));
      chk("dma_wait", 32'(dut.wait_cnt), 32'd0);
      chk("dma_m0_rdata", m0_rdata, 32'h0);
      if (k > 0) chk("dma_m1_rdata", m1_rdata, 32'h1234_5678);
    end

    // 4. Continuous contention: 8 denied cycles then a 4-beat burst, twice.
    m1_wr_en = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      m0_ram_en = 1'b1;
      m0_wr_en  = 1'b0;
      m1_req    = 1'b1;
      #1;
      chk("cont_gnt", {31'b0, m1_gnt}, ((k % 12) >= 8) ? 32'd1 : 32'd0);
      chk("cont_stall", {31'b0, cpu_stall}, ((k % 12) >= 8) ? 32'd1 : 32'd0);
      chk("cont_addr", ram_addr_o, ((k % 12) >= 8) ? 32'h20 : 32'h10);
      chk("cont_m0_rdata", m0_rdata, ((k % 12) >= 8) ? 32'h0 : 32'hDEAD_BEEF);
      chk("cont_m1_rdata", m1_rdata, ((k % 12) >= 8) ? 32'h1234_5678 : 32'h0);
    end

    // 5. Burst entered, DMA drops its request after 2 beats.
    repeat (10) @(negedge clk);
    #1;
    chk("drop_beat2_gnt", {31'b0, m1_gnt}, 32'd1);
    chk("drop_beat2_burst", 32'(dut.burst_cnt), 32'd1);
    @(negedge clk);
    m1_req = 1'b0;
    #1;
    chk("drop_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("drop_stall", {31'b0, cpu_stall}, 32'd0);
    chk("drop_ram_en", {31'b0, ram_en}, 32'd1);
    chk("drop_addr", ram_addr_o, 32'h10);
    chk("drop_st_dma", 32'(dut.st), 32'(S_DMA));
    @(negedge clk);
    #1;
    chk("drop_st_cpu", 32'(dut.st), 32'(S_CPU));
    chk("drop_burst0", 32'(dut.burst_cnt), 32'd0);

    // 6. Reset asserted during the third beat of a forced burst.
    @(negedge clk);
    m1_req = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("mid_gnt", {31'b0, m1_gnt}, 32'd1);
    chk("mid_stall", {31'b0, cpu_stall}, 32'd1);
`ifdef ARB_PERF_CNT_EN
    chk("perf_stall", stall_cycles, 32'd12);
    chk("perf_beats", dma_beats, 32'd15);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {31'b0, m1_gnt}, 32'd0);
    chk("mid_rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("mid_rst_ram_en", {31'b0, ram_en}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    m0_ram_en = 1'b0;
    m1_req    = 1'b0;
    #1;
    chk("post_st", 32'(dut.st), 32'(S_CPU));
    chk("post_wait", 32'(dut.wait_cnt), 32'd0);
    chk("post_burst", 32'(dut.burst_cnt), 32'd0);
    chk("post_ram_en", {31'b0, ram_en}, 32'd0);
`ifdef ARB_PERF_CNT_EN
    chk("post_perf_stall", stall_cycles, 32'd0);
    chk("post_perf_beats", dma_beats, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the single-port data RAM between two masters: the MIPS CPU data port (master 0) and a DMA/loader port (master 1) with a req/gnt handshake. It sits between MIPS_CPU and ram inside the SOPC. The CPU has default priority, and a `cpu_stall` output holds the CPU pipeline while the DMA owns the RAM. A wait counter and a burst counter bound starvation in both directions.

Parameters:
- DW, 32, data width; matches `DataWidth`.
- AW, 32, address width; matches `INS_ADDR_BUS`.
- MAX_WAIT, 8, number of contended cycles the DMA may be denied before it is forced a burst. Minimum 1.
- MAX_BURST, 4, maximum number of DMA beats per forced burst. Minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_ram_en  in  1  CPU access request, valid this cycle.
- m0_wr_en  in  1  CPU write (1) or read (0).
- m0_bits_sel  in  4  CPU byte lane select.
- m0_addr  in  AW  CPU address.
- m0_wdata  in  DW  CPU write data.
- m0_rdata  out  DW  CPU read data.
- cpu_stall  out  1  CPU must hold its request and its pipeline.
- m1_req  in  1  DMA access request.
- m1_wr_en  in  1  DMA write (1) or read (0).
- m1_bits_sel  in  4  DMA byte lane select.
- m1_addr  in  AW  DMA address.
- m1_wdata  in  DW  DMA write data.
- m1_gnt  out  1  DMA beat accepted this cycle.
- m1_rdata  out  DW  DMA read data.
- ram_en  out  1  to ram.
- wr_en  out  1  to ram.
- Bits_Sel  out  4  to ram.
- ram_addr_o  out  AW  to ram.
- data_to_ram  out  DW  to ram.
- data_from_ram  in  DW  from ram. Read data is combinational; writes commit on the clk edge.

Behaviour:
- One clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- State register is `st` ∈ {S_CPU, S_DMA}. Counters are `wait_cnt` and `burst_cnt`, each $clog2 of its limit plus 1 bits wide.
- Reset:
  - `st` = S_CPU and both counters = 0.
  - While `rst_n` = 0, all outputs are forced to 0, regardless of requests.
- Per-cycle owner is combinational from `st` and the requests; it is zero-latency.
  - S_CPU: owner = CPU if `m0_ram_en`; else DMA if `m1_req`; else NONE.
  - S_DMA: owner = DMA if `m1_req`; else CPU if `m0_ram_en`; else NONE.
- Owner CPU:
  - RAM outputs pass the m0_* signals.
  - `m0_rdata` = `data_from_ram`.
  - `cpu_stall` = 0 and `m1_gnt` = 0.
- Owner DMA:
  - RAM outputs pass the m1_* signals.
  - `m1_rdata` = `data_from_ram`.
  - `m1_gnt` = 1.
  - `cpu_stall` = `m0_ram_en`.
- Owner NONE: all RAM outputs are 0.
- The `rdata` of a non-owner is 0.
- Transitions in S_CPU:
  - `m1_req` & `m0_ram_en`: `wait_cnt`++. When `wait_cnt` == MAX_WAIT-1, next state is S_DMA and `wait_cnt` clears to 0.
  - `m1_req` & !`m0_ram_en`: the DMA beat is granted and `wait_cnt` clears to 0.
  - !`m1_req`: `wait_cnt` clears to 0.
- Transitions in S_DMA:
  - Each granted beat increments `burst_cnt`.
  - On the beat where `burst_cnt` == MAX_BURST-1, or in any cycle with `m1_req` = 0, next state is S_CPU and `burst_cnt` clears to 0.
- Simultaneous events:
  - A request that drops in S_DMA hands ownership to the CPU in the same cycle; there is no bubble.
  - A request arriving in the exit cycle is served next cycle under S_CPU rules.
- Reset mid-burst: the burst is abandoned with no resume. The DMA must keep or re-assert `m1_req`.
- Master rules:
  - The DMA must hold its request signals stable until `m1_gnt`.
  - The CPU holds its request signals while `cpu_stall` = 1.
- No combinational path exists from `cpu_stall` or `m1_gnt` back into the requests.

Optional Feature:
ARB_PERF_CNT_EN:
- Defined: adds output `stall_cycles[31:0]`, which counts cycles with `cpu_stall` = 1.
- Defined: adds output `dma_beats[31:0]`, which counts cycles with `m1_gnt` = 1.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: neither port nor counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Add to define.v: `S_CPU` / `S_DMA` encodings and the owner encodings `OWN_NONE` / `OWN_CPU` / `OWN_DMA`.
- Reuse `DataWidth` and `INS_ADDR_BUS` from define.v.
- One natural sub-module, `arb_sat_cnt` (a 32-bit saturating counter with enable), instantiated twice under ARB_PERF_CNT_EN.
- The FSM and the muxing stay in `ram_arbiter`.

Test Plan:
1. Hold `rst_n` = 0 with `m0_ram_en` = 1 and `m1_req` = 1 -> `ram_en` = 0, `cpu_stall` = 0, `m1_gnt` = 0. Release reset -> the CPU is granted in the first cycle.
2. CPU only: write addr 0x10, data 0xDEADBEEF, `bits_sel` 4'hF; read back next cycle -> `m0_rdata` = 0xDEADBEEF and `cpu_stall` stays 0.
3. DMA only: CPU idle, `m1_req` held 3 cycles -> `m1_gnt` = 1 on each cycle, `st` stays S_CPU, `wait_cnt` stays 0.
4. Continuous contention with MAX_WAIT = 8 and MAX_BURST = 4 -> `m1_gnt` = 0 for 8 cycles, then `m1_gnt` = 1 with `cpu_stall` = 1 for 4 cycles, then the CPU is granted and the pattern repeats.
5. In S_DMA, `m1_req` drops after 2 beats -> the CPU is granted in that same cycle, `cpu_stall` = 0, `st` returns to S_CPU.
6. Assert `rst_n` low mid-burst (after beat 2) -> `cpu_stall` and `m1_gnt` drop to 0 immediately. After release, `st` = S_CPU and both counters = 0. With ARB_PERF_CNT_EN defined, both counts read 0.
